rotate_tile_sched: RTL and testbench
====================================

Name: rotate_tile_sched

Overview:
Frame-level scheduler for the rotate engine. It splits a WIDTH x HEIGHT RGB frame into 8x8-pixel tiles and processes each tile in three phases:
- commands the AHB master to read the tile into the input buffer;
- pulses the pixel core to run its read/write sequence for that tile;
- commands the AHB master to write the rotated tile to its destination slot.

It sits between the register block and both the AHB master and the pixel core.

Parameters:
TILE_BYTES, 192, bytes per 8x8 RGB tile (64 px x 3 B); used as the address stride.
ADDR_W, 32, width of the AHB address outputs.

Ports:
I_TS_HCLK  in  1  system clock
I_TS_HRESET_N  in  1  reset, asynchronous, active-low
I_TS_RESET  in  1  synchronous soft reset
I_TS_START  in  1  frame start pulse
I_TS_WIDTH  in  16  frame width in pixels
I_TS_HEIGHT  in  16  frame height in pixels
I_TS_DEGREES  in  2  0=0, 1=90, 2=180, 3=270
I_TS_DIRECTION  in  1  1=counter-clockwise, 0=clockwise
I_TS_SRC_BASE  in  ADDR_W  source frame base address
I_TS_DST_BASE  in  ADDR_W  destination frame base address
O_TS_RD_REQ  out  1  tile read request to AHB master
O_TS_RD_ADDR  out  ADDR_W  tile read address
I_TS_RD_ACK  in  1  read request accepted
I_TS_RD_DONE  in  1  read burst complete (pulse)
O_TS_CORE_START  out  1  one-cycle start pulse to pixel core
I_TS_CORE_DONE  in  1  core finished tile (pulse)
O_TS_WR_REQ  out  1  tile write request to AHB master
O_TS_WR_ADDR  out  ADDR_W  tile write address
I_TS_WR_ACK  in  1  write request accepted
I_TS_WR_DONE  in  1  write burst complete (pulse)
O_TS_BUSY  out  1  frame in progress
O_TS_DONE  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (I_TS_HRESET_N low, async): state IDLE; every output 0; tile counters 0.
- I_TS_RESET (sync, highest priority after async reset):
  - same clear as async reset, next edge;
  - no DONE pulse is issued;
  - outstanding AHB/core transactions are abandoned.
- Config latch: on START in IDLE, latch WIDTH, HEIGHT, DEGREES, DIRECTION and both bases. START while BUSY is ignored.
- Tile grid:
  - tiles_x = ceil(W/8), tiles_y = ceil(H/8) (computed as (W+7)>>3 in 17-bit arithmetic);
  - tiles are visited in raster order: tx fastest, then ty.
- Effective rotation: DIRECTION=1 swaps 90 and 270; 0 and 180 are unchanged.
- Source address: SRC_BASE + (ty*tiles_x + tx)*TILE_BYTES.
- Destination tile (dx, dy) and destination grid width dw, by effective clockwise angle:
  - 0: (tx, ty), dw = tiles_x;
  - 90: (tiles_y-1-ty, tx), dw = tiles_y;
  - 180: (tiles_x-1-tx, tiles_y-1-ty), dw = tiles_x;
  - 270: (ty, tiles_x-1-tx), dw = tiles_y.
- Destination address: DST_BASE + (dy*dw + dx)*TILE_BYTES, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- Addresses are registered, computed in CALC, and held stable while the matching REQ is high.
- States:
  - IDLE: on START with W=0 or H=0, pulse DONE the next cycle and stay IDLE; otherwise go to CALC, BUSY=1.
  - CALC: one cycle, compute both addresses, go to RD_REQ.
  - RD_REQ: RD_REQ=1 until RD_ACK is sampled high; REQ drops the cycle after ACK; go to RD_WAIT.
  - RD_WAIT: on RD_DONE go to CORE; CORE_START=1 for exactly the following cycle.
  - CORE: wait for CORE_DONE, then go to WR_REQ.
  - WR_REQ: same handshake as RD_REQ; go to WR_WAIT.
  - WR_WAIT: on WR_DONE go to NEXT.
  - NEXT: if (tx, ty) is the last tile, go to FIN; else advance tx (at tiles_x-1 wrap tx to 0 and ty+1), then go to CALC.
  - FIN: DONE=1, BUSY=0 for one cycle, then IDLE.
- ACK and DONE sampled in the same cycle as REQ: ACK is taken; the DONE is ignored. A DONE is only recognised in its own WAIT state.
- Minimum tile period: 7 cycles when every ACK/DONE returns in zero cycles.

Optional Feature:
Macro ROTATE_TILE_SCHED_PERF_EN.
- Defined: adds output O_TS_CYCLES[31:0].
  - Cleared on accepted START; increments every cycle while BUSY; saturates at 0xFFFFFFFF.
  - Holds its value after DONE until the next START; cleared by either reset.
- Undefined: no port and no counter logic.

Test Plan:
- W=16, H=8, DEG=0, SRC=0x1000, DST=0x8000, zero-delay ACK/DONE -> RD_ADDR 0x1000 then 0x10C0; WR_ADDR 0x8000 then 0x80C0; 2 CORE_START pulses; one DONE.
- W=16, H=16, DEG=1, DIR=0 (90 CW) -> RD 0x1000, 0x10C0, 0x1180, 0x1240; WR 0x80C0, 0x8240, 0x8000, 0x8180.
- Same frame with DIR=1, DEG=3 -> WR sequence identical to the previous case; DIR=1, DEG=1 -> WR 0x8180, 0x8000, 0x8240, 0x80C0.
- W=9, H=1 -> tiles_x=2, tiles_y=1; exactly 2 tiles processed. W=0 -> DONE one cycle after START, no REQ.
- START pulsed during CORE -> ignored, tile count unchanged. I_TS_RESET asserted in WR_WAIT -> all outputs 0 next cycle, no DONE.
- ACK delayed 5 cycles -> REQ and address held stable for all 5 cycles. I_TS_HRESET_N dropped mid-frame -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rotate_tile_sched.sv
// rtl/rotate_tile_sched.sv - 8x8 tile read/core/write scheduler for the rotate engine
// Optional cycle counter port O_TS_CYCLES when ROTATE_TILE_SCHED_PERF_EN is defined.
module rotate_tile_sched #(
    parameter int TILE_BYTES = 192,
    parameter int ADDR_W     = 32
) (
    input  logic              I_TS_HCLK,
    input  logic              I_TS_HRESET_N,
    input  logic              I_TS_RESET,
    input  logic              I_TS_START,
    input  logic [15:0]       I_TS_WIDTH,
    input  logic [15:0]       I_TS_HEIGHT,
    input  logic [1:0]        I_TS_DEGREES,
    input  logic              I_TS_DIRECTION,
    input  logic [ADDR_W-1:0] I_TS_SRC_BASE,
    input  logic [ADDR_W-1:0] I_TS_DST_BASE,
    output logic              O_TS_RD_REQ,
    output logic [ADDR_W-1:0] O_TS_RD_ADDR,
    input  logic              I_TS_RD_ACK,
    input  logic              I_TS_RD_DONE,
    output logic              O_TS_CORE_START,
    input  logic              I_TS_CORE_DONE,
    output logic              O_TS_WR_REQ,
    output logic [ADDR_W-1:0] O_TS_WR_ADDR,
    input  logic              I_TS_WR_ACK,
    input  logic              I_TS_WR_DONE,
    output logic              O_TS_BUSY,
    output logic              O_TS_DONE
`ifdef ROTATE_TILE_SCHED_PERF_EN
    ,
    output logic [31:0]       O_TS_CYCLES
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CALC,
        S_RD_REQ,
        S_RD_WAIT,
        S_CORE,
        S_WR_REQ,
        S_WR_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [13:0]       tiles_x_q, tiles_x_d, tiles_y_q, tiles_y_d;
    logic [13:0]       tx_q, tx_d, ty_q, ty_d;
    logic [1:0]        rot_q, rot_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic              core_start_q, core_start_d;
    logic              zdone_q, zdone_d;
    logic              load_cfg;
    logic [13:0]       dx, dy, dw;
    logic [27:0]       src_idx, dst_idx;
    logic              last_x, last_y;

    // Destination tile position for the effective clockwise angle held in rot_q
    always_comb begin
        dx = tx_q;
        dy = ty_q;
        dw = tiles_x_q;
        case (rot_q)
            2'd1: begin dx = tiles_y_q - 14'd1 - ty_q; dy = tx_q; dw = tiles_y_q; end
            2'd2: begin dx = tiles_x_q - 14'd1 - tx_q; dy = tiles_y_q - 14'd1 - ty_q; end
            2'd3: begin dx = ty_q; dy = tiles_x_q - 14'd1 - tx_q; dw = tiles_y_q; end
            default: ;
        endcase
    end

    assign src_idx = 28'(ty_q) * 28'(tiles_x_q) + 28'(tx_q);
    assign dst_idx = 28'(dy) * 28'(dw) + 28'(dx);
    assign last_x  = (tx_q == tiles_x_q - 14'd1);
    assign last_y  = (ty_q == tiles_y_q - 14'd1);

    always_comb begin
        state_d      = state_q;
        tiles_x_d    = tiles_x_q;
        tiles_y_d    = tiles_y_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        rot_d        = rot_q;
        src_base_d   = src_base_q;
        dst_base_d   = dst_base_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        core_start_d = 1'b0;
        zdone_d      = 1'b0;
        load_cfg     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_TS_START) begin
                    load_cfg   = 1'b1;
                    tiles_x_d  = 14'((17'(I_TS_WIDTH) + 17'd7) >> 3);
                    tiles_y_d  = 14'((17'(I_TS_HEIGHT) + 17'd7) >> 3);
                    tx_d       = '0;
                    ty_d       = '0;
                    // Counter-clockwise folds onto clockwise by swapping 90 and 270
                    rot_d      = {I_TS_DEGREES[1] ^ (I_TS_DIRECTION & I_TS_DEGREES[0]),
                                  I_TS_DEGREES[0]};
                    src_base_d = I_TS_SRC_BASE;
                    dst_base_d = I_TS_DST_BASE;
                    if (I_TS_WIDTH == 16'd0 || I_TS_HEIGHT == 16'd0) begin
                        zdone_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rd_addr_d = src_base_q + ADDR_W'(src_idx) * ADDR_W'(TILE_BYTES);
                wr_addr_d = dst_base_q + ADDR_W'(dst_idx) * ADDR_W'(TILE_BYTES);
                state_d   = S_RD_REQ;
            end
            S_RD_REQ: if (I_TS_RD_ACK) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (I_TS_RD_DONE) begin
                    state_d      = S_CORE;
                    core_start_d = 1'b1;
                end
            end
            S_CORE:    if (I_TS_CORE_DONE) state_d = S_WR_REQ;
            S_WR_REQ:  if (I_TS_WR_ACK) state_d = S_WR_WAIT;
            S_WR_WAIT: if (I_TS_WR_DONE) state_d = S_NEXT;
            S_NEXT: begin
                if (last_x && last_y) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_CALC;
                    if (last_x) begin
                        tx_d = '0;
                        ty_d = ty_q + 14'd1;
                    end else begin
                        tx_d = tx_q + 14'd1;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_TS_HCLK or negedge I_TS_HRESET_N) begin
        if (!I_TS_HRESET_N) begin
            state_q      <= S_IDLE;
            tiles_x_q    <= '0;
            tiles_y_q    <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            rot_q        <= '0;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            core_start_q <= 1'b0;
            zdone_q      <= 1'b0;
        end else if (I_TS_RESET) begin
            state_q      <= S_IDLE;
            tiles_x_q    <= '0;
            tiles_y_q    <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            rot_q        <= '0;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            core_start_q <= 1'b0;
            zdone_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tiles_x_q    <= tiles_x_d;
            tiles_y_q    <= tiles_y_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            rot_q        <= rot_d;
            src_base_q   <= src_base_d;
            dst_base_q   <= dst_base_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            core_start_q <= core_start_d;
            zdone_q      <= zdone_d;
        end
    end

    assign O_TS_RD_REQ     = (state_q == S_RD_REQ);
    assign O_TS_WR_REQ     = (state_q == S_WR_REQ);
    assign O_TS_RD_ADDR    = rd_addr_q;
    assign O_TS_WR_ADDR    = wr_addr_q;
    assign O_TS_CORE_START = core_start_q;
    assign O_TS_BUSY       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign O_TS_DONE       = (state_q == S_FIN) || zdone_q;

`ifdef ROTATE_TILE_SCHED_PERF_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (load_cfg) begin
            cycles_d = '0;
        end else if (O_TS_BUSY && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge I_TS_HCLK or negedge I_TS_HRESET_N) begin
        if (!I_TS_HRESET_N) begin
            cycles_q <= '0;
        end else if (I_TS_RESET) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign O_TS_CYCLES = cycles_q;
`endif

endmodule

// File: tb/tb_rotate_tile_sched.sv
// tb/tb_rotate_tile_sched.sv - scoreboard bench for rotate_tile_sched
`timescale 1ns/1ps
module tb_rotate_tile_sched;
    localparam int TB_BYTES = 192;
    localparam int K_RD = 0, K_CORE = 1, K_WR = 2, K_DONE = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
    } ev_t;
    ev_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] w = '0, h = '0;
    logic [1:0]  deg = '0;
    logic        dir = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic        rd_req, wr_req, core_start, busy, done;
    logic [31:0] rd_addr, wr_addr;
    logic        rd_ack = 1'b0, rd_done = 1'b0, wr_ack = 1'b0, wr_done = 1'b0, core_done = 1'b0;
`ifdef ROTATE_TILE_SCHED_PERF_EN
    logic [31:0] cycles;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int cyc = 0;
    int core_cyc[$];
    int ack_lo = 0, ack_hi = 0, dly_lo = 0, dly_hi = 0;
    bit hold_core = 1'b0, hold_wr = 1'b0;

    rotate_tile_sched #(.TILE_BYTES(192), .ADDR_W(32)) dut (
        .I_TS_HCLK(clk), .I_TS_HRESET_N(rst_n), .I_TS_RESET(soft_rst), .I_TS_START(start),
        .I_TS_WIDTH(w), .I_TS_HEIGHT(h), .I_TS_DEGREES(deg), .I_TS_DIRECTION(dir),
        .I_TS_SRC_BASE(src), .I_TS_DST_BASE(dst),
        .O_TS_RD_REQ(rd_req), .O_TS_RD_ADDR(rd_addr), .I_TS_RD_ACK(rd_ack), .I_TS_RD_DONE(rd_done),
        .O_TS_CORE_START(core_start), .I_TS_CORE_DONE(core_done),
        .O_TS_WR_REQ(wr_req), .O_TS_WR_ADDR(wr_addr), .I_TS_WR_ACK(wr_ack), .I_TS_WR_DONE(wr_done),
        .O_TS_BUSY(busy), .O_TS_DONE(done)
`ifdef ROTATE_TILE_SCHED_PERF_EN
        , .O_TS_CYCLES(cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] addr, input string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event kind %0d, want none", nm, kind);
            return;
        end
        e = exp_q.pop_front();
        check({nm, "_kind"}, 32'(kind), 32'(e.kind));
        if (kind == K_RD || kind == K_WR) check({nm, "_addr"}, addr, e.addr);
    endtask

    // Reference: raster walk of the tile grid, destination found by rotating
    // the grid 90 degrees clockwise k times.
    task automatic push_frame(input int W, input int H, input int dg, input int dr,
                              input logic [31:0] sb, input logic [31:0] db);
        int txn, tyn, k, x, y, gw, gh, t;
        longint sa, da;
        ev_t e;
        txn = (W + 7) / 8;
        tyn = (H + 7) / 8;
        if (W == 0 || H == 0) begin
            e.kind = K_DONE; e.addr = '0; exp_q.push_back(e);
            return;
        end
        k = (dr != 0) ? (4 - dg) % 4 : dg;
        for (int ty = 0; ty < tyn; ty++) begin
            for (int tx = 0; tx < txn; tx++) begin
                x = tx; y = ty; gw = txn; gh = tyn;
                for (int r = 0; r < k; r++) begin
                    t = x; x = gh - 1 - y; y = t;
                    t = gw; gw = gh; gh = t;
                end
                sa = longint'(sb) + longint'(ty * txn + tx) * TB_BYTES;
                da = longint'(db) + longint'(y * gw + x) * TB_BYTES;
                e.kind = K_RD;   e.addr = sa[31:0]; exp_q.push_back(e);
                e.kind = K_CORE; e.addr = '0;       exp_q.push_back(e);
                e.kind = K_WR;   e.addr = da[31:0]; exp_q.push_back(e);
            end
        end
        e.kind = K_DONE; e.addr = '0; exp_q.push_back(e);
    endtask

    // Monitor: handshake rules and scoreboard pops
    initial begin
        logic a_rd, a_wr, rst_s, p_rd, p_wr;
        logic [31:0] h_rd, h_wr;
        p_rd = 1'b0; p_wr = 1'b0; h_rd = '0; h_wr = '0;
        forever begin
            @(posedge clk);
            a_rd = rd_ack; a_wr = wr_ack; rst_s = soft_rst || !rst_n;
            #1;
            cyc++;
            if (!rst_s && rst_n) begin
                if (p_rd) begin
                    if (a_rd) check("rd_req_drop", 32'(rd_req), 32'd0);
                    else begin
                        check("rd_req_hold", 32'(rd_req), 32'd1);
                        check("rd_addr_hold", rd_addr, h_rd);
                    end
                end else if (rd_req) pop_cmp(K_RD, rd_addr, "rd");
                if (p_wr) begin
                    if (a_wr) check("wr_req_drop", 32'(wr_req), 32'd0);
                    else begin
                        check("wr_req_hold", 32'(wr_req), 32'd1);
                        check("wr_addr_hold", wr_addr, h_wr);
                    end
                end else if (wr_req) pop_cmp(K_WR, wr_addr, "wr");
                if (core_start) begin
                    pop_cmp(K_CORE, 32'd0, "core");
                    core_cyc.push_back(cyc);
                end
                if (done) begin
                    pop_cmp(K_DONE, 32'd0, "done");
                    check("busy_at_done", 32'(busy), 32'd0);
                    done_cnt++;
                end
            end
            p_rd = rd_req; p_wr = wr_req; h_rd = rd_addr; h_wr = wr_addr;
        end
    end

    // Responder: AHB master and pixel core with programmable latencies
    initial begin
        int rph, rcnt, wph, wcnt, cph, ccnt;
        rph = 0; rcnt = 0; wph = 0; wcnt = 0; cph = 0; ccnt = 0;
        forever begin
            @(negedge clk);
            #1;
            rd_ack = 0; rd_done = 0; wr_ack = 0; wr_done = 0; core_done = 0;
            if (!rst_n || soft_rst) begin
                rph = 0; wph = 0; cph = 0;
            end else begin
                if (rph == 0 && rd_req) begin rph = 1; rcnt = int'($urandom_range(ack_hi, ack_lo)); end
                if (rph == 1) begin
                    if (rcnt == 0) begin rd_ack = 1; rph = 2; rcnt = int'($urandom_range(dly_hi, dly_lo)); end
                    else rcnt--;
                end else if (rph == 2) begin
                    if (rcnt == 0) begin rd_done = 1; rph = 0; end
                    else rcnt--;
                end
                if (cph == 0 && core_start) begin cph = 1; ccnt = int'($urandom_range(dly_hi, dly_lo)); end
                if (cph == 1 && !hold_core) begin
                    if (ccnt == 0) begin core_done = 1; cph = 0; end
                    else ccnt--;
                end
                if (wph == 0 && wr_req) begin wph = 1; wcnt = int'($urandom_range(ack_hi, ack_lo)); end
                if (wph == 1) begin
                    if (wcnt == 0) begin wr_ack = 1; wph = 2; wcnt = int'($urandom_range(dly_hi, dly_lo)); end
                    else wcnt--;
                end else if (wph == 2 && !hold_wr) begin
                    if (wcnt == 0) begin wr_done = 1; wph = 0; end
                    else wcnt--;
                end
            end
        end
    end

    task automatic do_start(input int W, input int H, input int dg, input int dr,
                            input logic [31:0] sb, input logic [31:0] db);
        @(negedge clk);
        w = 16'(W); h = 16'(H); deg = 2'(dg); dir = 1'(dr); src = sb; dst = db;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input string nm);
        int n;
        n = 0;
        while (done_cnt == c0 && n < 4000) begin @(negedge clk); n++; end
        if (done_cnt == c0) begin
            total++; bad++;
            $display("FAIL %s_timeout: no DONE after %0d cycles, want DONE", nm, n);
        end
        check({nm, "_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input int W, input int H, input int dg, input int dr,
                             input logic [31:0] sb, input logic [31:0] db, input string nm);
        int c0;
        c0 = done_cnt;
        push_frame(W, H, dg, dr, sb, db);
        do_start(W, H, dg, dr, sb, db);
        wait_done(c0, nm);
    endtask

    task automatic check_zero_outs(input string nm);
        check({nm, "_rd_req"}, 32'(rd_req), 32'd0);
        check({nm, "_wr_req"}, 32'(wr_req), 32'd0);
        check({nm, "_core_start"}, 32'(core_start), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_rd_addr"}, rd_addr, 32'd0);
        check({nm, "_wr_addr"}, wr_addr, 32'd0);
    endtask

    task automatic wait_sig(input int which, input logic val, input string nm);
        int n;
        logic s;
        n = 0;
        s = (which == 0) ? core_start : wr_req;
        while (s !== val && n < 500) begin
            @(negedge clk); n++;
            s = (which == 0) ? core_start : wr_req;
        end
        if (s !== val) begin
            total++; bad++;
            $display("FAIL %s: signal stuck at %b, want %b", nm, s, val);
        end
    endtask

    initial begin
        int c0, W, H;
        repeat (3) @(negedge clk);
        check_zero_outs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        core_cyc.delete();
        run_frame(16, 8, 0, 0, 32'h1000, 32'h8000, "deg0");
        check("core_pulses", 32'(core_cyc.size()), 32'd2);
        if (core_cyc.size() == 2) check("tile_period", 32'(core_cyc[1] - core_cyc[0]), 32'd7);
        run_frame(16, 16, 1, 0, 32'h1000, 32'h8000, "cw90");
        run_frame(16, 16, 3, 1, 32'h1000, 32'h8000, "ccw270");
        run_frame(16, 16, 1, 1, 32'h1000, 32'h8000, "ccw90");
        run_frame(16, 16, 2, 0, 32'h1000, 32'h8000, "cw180");
        run_frame(9, 1, 0, 0, 32'h2000, 32'h9000, "w9h1");
        run_frame(16, 8, 0, 0, 32'h1000, 32'hFFFF_FF40, "wrap");

        c0 = done_cnt;
        push_frame(0, 5, 0, 0, 32'h0, 32'h0);
        do_start(0, 5, 0, 0, 32'h1000, 32'h8000);
        check("zero_done_next", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_rd_req", 32'(rd_req), 32'd0);
        @(negedge clk);
        check("zero_done_pulse", 32'(done), 32'd0);
        wait_done(c0, "w0");
        run_frame(7, 0, 0, 0, 32'h1000, 32'h8000, "h0");

        ack_lo = 5; ack_hi = 5;
        run_frame(16, 8, 1, 0, 32'h4000, 32'hA000, "ack5");
        ack_lo = 0; ack_hi = 0;

        // START while the core is running must not restart or extend the frame
        hold_core = 1'b1;
        c0 = done_cnt;
        push_frame(16, 8, 2, 0, 32'h3000, 32'hB000);
        do_start(16, 8, 2, 0, 32'h3000, 32'hB000);
        wait_sig(0, 1'b1, "core_wait");
        do_start(40, 40, 0, 0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("busy_in_core", 32'(busy), 32'd1);
        hold_core = 1'b0;
        wait_done(c0, "start_in_core");

        // Soft reset while waiting for the write burst
        hold_wr = 1'b1;
        push_frame(16, 8, 0, 0, 32'h1000, 32'h8000);
        do_start(16, 8, 0, 0, 32'h1000, 32'h8000);
        wait_sig(1, 1'b1, "wr_req_rise");
        wait_sig(1, 1'b0, "wr_req_fall");
        c0 = done_cnt;
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        check_zero_outs("soft_rst");
        exp_q.delete();
        hold_wr = 1'b0;
        repeat (10) @(negedge clk);
        check("soft_rst_no_done", 32'(done_cnt), 32'(c0));

        // Asynchronous reset mid-frame
        ack_lo = 0; ack_hi = 3; dly_lo = 0; dly_hi = 3;
        push_frame(40, 40, 1, 0, 32'h1000, 32'h8000);
        do_start(40, 40, 1, 0, 32'h1000, 32'h8000);
        repeat (15) @(negedge clk);
        check("busy_mid", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero_outs("async_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            W = int'($urandom_range(48, 1));
            H = int'($urandom_range(48, 1));
            if ($urandom_range(9, 0) == 0) W = 0;
            ack_hi = int'($urandom_range(4, 0));
            dly_hi = int'($urandom_range(4, 0));
            run_frame(W, H, int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                      $urandom, $urandom, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
